// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the external memory bus between the MEM-stage data-cache port (DC_*)
//   and the instruction-fetch port (IC_*). One owner at a time; the granted
//   request is latched and held on the bus until BUS_ACK_SX. The data side has
//   priority, but after STARVE_MAX back-to-back data grants with fetch waiting,
//   fetch is forced through.
//
//   Optional build macro: BUS_TIMEOUT_EN
//     defined   -> a watchdog ends a transfer that has had no ACK for
//                  TIMEOUT_CYCLES cycles. The owner gets result 0 and an error pulse.
//     undefined -> the arbiter waits for ACK indefinitely.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   DC_*_SM   (in)        data request: valid, addr, store data, store/load, byte enables
//   DC_STALL_SA (out)     data side must hold its request
//   DC_RESULT_SA (out)    load data (combinational from the bus read data)
//   DC_BUS_ERROR_SA (out) one-cycle data bus error pulse
//   IC_ADR_VALID_SI/IC_ADR_SI (in) fetch request
//   IC_STALL_SA/IC_INST_SA/IC_FAULT_SA (out) fetch stall, word, error pulse
//   BUS_*_SA  (out)       external bus request, addr, wdata, write enable, byte enables
//   BUS_ACK_SX/BUS_RDATA_SX/BUS_ERR_SX (in) bus handshake, read data, error
module mem_bus_arbiter #(
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        DC_ADR_VALID_SM,
    input  logic [31:0] DC_ADR_SM,
    input  logic [31:0] DC_DATA_SM,
    input  logic        DC_STORE_SM,
    input  logic        DC_LOAD_SM,
    input  logic [3:0]  DC_BYT_SEL_SM,
    output logic        DC_STALL_SA,
    output logic [31:0] DC_RESULT_SA,
    output logic        DC_BUS_ERROR_SA,
    input  logic        IC_ADR_VALID_SI,
    input  logic [31:0] IC_ADR_SI,
    output logic        IC_STALL_SA,
    output logic [31:0] IC_INST_SA,
    output logic        IC_FAULT_SA,
    output logic        BUS_REQ_SA,
    output logic [31:0] BUS_ADR_SA,
    output logic [31:0] BUS_WDATA_SA,
    output logic        BUS_WE_SA,
    output logic [3:0]  BUS_BE_SA,
    input  logic        BUS_ACK_SX,
    input  logic [31:0] BUS_RDATA_SX,
    input  logic        BUS_ERR_SX
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } bus_req_t;

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_L = SW'(STARVE_MAX);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_tmo;
    logic          w_done;
    logic [SW-1:0] r_starve;
    bus_req_t      r_req;
    logic          r_dc_err;
    logic          r_ic_err;
    logic          w_unused;

    // DC_LOAD_SM is implied by valid & !store; kept on the port for the pipeline.
    assign w_unused = DC_LOAD_SM & (TIMEOUT_CYCLES > 0);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_tmo_cnt;

    // Zero on the first owned cycle, so TMO_LAST marks the last allowed cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              r_tmo_cnt <= '0;
        else if (r_state == IDLE)  r_tmo_cnt <= '0;
        else                       r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_tmo = (r_state != IDLE) & ~BUS_ACK_SX & (r_tmo_cnt == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    // Transfer ends this cycle, by ACK or by watchdog.
    assign w_done = (r_state != IDLE) & (BUS_ACK_SX | w_tmo);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state / arbitration
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        case (r_state)
            IDLE: begin
                if (DC_ADR_VALID_SM && (!IC_ADR_VALID_SI || r_starve < STARVE_L)) begin
                    w_state_nxt = DATA;
                    w_grant_d   = 1'b1;
                end else if (IC_ADR_VALID_SI) begin
                    w_state_nxt = INST;
                    w_grant_i   = 1'b1;
                end
            end
            DATA, INST: begin
                if (w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs. Stall drops in the completion cycle so the requester can pop then.
    always_comb begin
        BUS_REQ_SA   = (r_state != IDLE);
        DC_STALL_SA  = DC_ADR_VALID_SM & ~((r_state == DATA) & w_done);
        IC_STALL_SA  = IC_ADR_VALID_SI & ~((r_state == INST) & w_done);
        DC_RESULT_SA = w_tmo ? 32'h0 : BUS_RDATA_SX;
        IC_INST_SA   = w_tmo ? 32'h0 : BUS_RDATA_SX;
    end

    // Fetch-starvation counter: counts data grants that passed a waiting fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_starve <= '0;
        else if (!IC_ADR_VALID_SI || w_grant_i)
            r_starve <= '0;
        else if (w_grant_d && r_starve != STARVE_L)
            r_starve <= r_starve + 1'b1;
    end

    // Latched bus request; requester changes during a transfer are not seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_req <= '0;
        else if (w_grant_d)
            r_req <= '{adr: DC_ADR_SM, wdata: DC_DATA_SM, we: DC_STORE_SM, be: DC_BYT_SEL_SM};
        else if (w_grant_i)
            r_req <= '{adr: IC_ADR_SI, wdata: 32'h0, we: 1'b0, be: 4'b1111};
    end

    assign BUS_ADR_SA   = r_req.adr;
    assign BUS_WDATA_SA = r_req.wdata;
    assign BUS_WE_SA    = r_req.we;
    assign BUS_BE_SA    = r_req.be;

    // Error pulses, one cycle after completion; suppressed if the owner has
    // already withdrawn its request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dc_err <= 1'b0;
            r_ic_err <= 1'b0;
        end else begin
            r_dc_err <= (r_state == DATA) & DC_ADR_VALID_SM & ((BUS_ACK_SX & BUS_ERR_SX) | w_tmo);
            r_ic_err <= (r_state == INST) & IC_ADR_VALID_SI & ((BUS_ACK_SX & BUS_ERR_SX) | w_tmo);
        end
    end

    assign DC_BUS_ERROR_SA = r_dc_err;
    assign IC_FAULT_SA     = r_ic_err;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single external memory bus between the MEM-stage data-cache port and the instruction-fetch port. It grants one requester at a time and holds the request stable on the bus until acknowledge. It returns read data and stall to each side and reports bus errors back into the pipeline, feeding mem's MCACHE_STALL_SM, MCACHE_RESULT_SM and BUS_ERROR_SX. Data side has priority, with a starvation guard for fetch.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting before fetch is forced.
TIMEOUT_CYCLES, 64, watchdog limit in cycles (only with BUS_TIMEOUT_EN).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
DC_ADR_VALID_SM  in  1  data request valid
DC_ADR_SM  in  32  data address
DC_DATA_SM  in  32  store data
DC_STORE_SM  in  1  store request
DC_LOAD_SM  in  1  load request
DC_BYT_SEL_SM  in  4  byte enables
DC_STALL_SA  out  1  data side must hold request
DC_RESULT_SA  out  32  load data, valid when DC_STALL_SA low after a request
DC_BUS_ERROR_SA  out  1  one-cycle data bus error pulse
IC_ADR_VALID_SI  in  1  fetch request valid
IC_ADR_SI  in  32  fetch address
IC_STALL_SA  out  1  fetch side must hold request
IC_INST_SA  out  32  fetched word
IC_FAULT_SA  out  1  one-cycle fetch bus error pulse
BUS_REQ_SA  out  1  bus request
BUS_ADR_SA  out  32  bus address
BUS_WDATA_SA  out  32  bus write data
BUS_WE_SA  out  1  bus write enable
BUS_BE_SA  out  4  bus byte enables
BUS_ACK_SX  in  1  bus acknowledge, one cycle per transfer
BUS_RDATA_SX  in  32  bus read data, valid with BUS_ACK_SX
BUS_ERR_SX  in  1  bus error, valid with BUS_ACK_SX

Behaviour:
- Clock and reset are fixed: one clock, clk; reset_n is asynchronous and active-low.
- FSM states: IDLE, DATA, INST. Reset -> IDLE, starve counter 0, all bus registers 0.
- Reset values: BUS_REQ_SA=0, BUS_WE_SA=0, BUS_ADR/WDATA/BE=0, error pulses=0.
- IDLE arbitration:
  - data request only -> DATA.
  - fetch request only -> INST.
  - both, with starve counter < STARVE_MAX -> DATA, counter+1.
  - both, with counter == STARVE_MAX -> INST.
  - no request -> stay in IDLE.
- Grant latches address, wdata, WE (=DC_STORE_SM), and BE (data side) into registers. Fetch uses BE=4'b1111 and WE=0.
- Starve counter:
  - clears when INST is granted or fetch is not requesting.
  - saturates at STARVE_MAX.
- BUS_REQ_SA=1 in DATA/INST; bus outputs are stable from the registers until ACK.
- Timing: request seen in IDLE at cycle N; BUS_REQ_SA high from N+1; ACK accepted at N+1 at the earliest. Minimum access is 2 cycles.
- On BUS_ACK_SX: return to IDLE next cycle. A back-to-back grant is possible from IDLE one cycle later; there is no grant on the ACK cycle itself.
- DC_STALL_SA = DC_ADR_VALID_SM & !(state==DATA & BUS_ACK_SX). This is combinational so mem pops its FIFO in the ACK cycle. IC_STALL_SA is the same for the fetch side.
- DC_RESULT_SA and IC_INST_SA are combinational from BUS_RDATA_SX. Consumers sample them only when their stall is low.
- Bus error with ACK: DC_BUS_ERROR_SA or IC_FAULT_SA is registered and pulses for exactly 1 cycle after the ACK. The transfer still completes, and stall drops normally.
- Requester drops valid mid-transfer: the transfer completes on the bus, the result is discarded, and no error pulse is raised.
- No request pending: stall outputs are 0.
- Reset asserted mid-transfer: immediate return to IDLE with BUS_REQ_SA=0. A later ACK while in IDLE is ignored.
- Address or data changes from a requester during a transfer are ignored; only the latched copy drives the bus.

Optional Feature:
BUS_TIMEOUT_EN
- Defined: a cycle counter runs in DATA/INST and clears on grant. If no ACK arrives by TIMEOUT_CYCLES, the transfer terminates:
  - BUS_REQ_SA drops.
  - FSM returns to IDLE.
  - the owner's stall drops for one cycle with result 0.
  - the owner's error pulse fires.
- Undefined: no counter; the arbiter waits for ACK indefinitely.

Test Plan:
- Data load only, ADR=0x100, ACK 3 cycles after BUS_REQ with RDATA=0xDEADBEEF -> DC_STALL_SA high 3 cycles, then low with DC_RESULT_SA=0xDEADBEEF; BUS_WE_SA=0.
- Data store, BE=4'b0011, DATA=0x0000ABCD -> BUS_WE=1, BUS_BE=0011, BUS_WDATA=0xABCD held until ACK.
- Both requesting continuously, 1-cycle ACK, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Data load with ACK+ERR -> DC_BUS_ERROR_SA=1 for exactly one cycle after ACK; IC_FAULT_SA stays 0.
- Fetch in flight, reset_n pulsed low, then ACK arrives -> BUS_REQ_SA=0 immediately; ACK ignored; FSM in IDLE.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ACK -> BUS_REQ_SA falls after 8 cycles; DC_BUS_ERROR_SA pulses; DC_RESULT_SA=0.
